// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair comparator for the RO PUF: counts edges of two selected ROs over a window and reports A faster than B.
// Optional build macro ROPUF_TIE_FLAG_EN adds a registered tie output flagging equal counts.
module ro_pair_compare #(
  parameter int unsigned WINDOW = 1024,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] challenge,
  input  logic       ro_a,
  input  logic       ro_b,
  output logic [3:0] sel_a,
  output logic [3:0] sel_b,
  output logic       busy,
  output logic       done,
  output logic       resp
`ifdef ROPUF_TIE_FLAG_EN
  ,
  output logic       tie
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;

  localparam int unsigned TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0]    WINDOW_LAST = TW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t state_q, state_d;
  logic   accept;

  logic [2:0]       sync_a, sync_b;
  logic             edge_a, edge_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic [CNT_W-1:0] cnt_a_nx, cnt_b_nx;
  logic [TW-1:0]    timer;
  logic             window_end;

  // Two synchronizer flops followed by a history flop for rising-edge detection.
  assign edge_a = sync_a[1] & ~sync_a[2];
  assign edge_b = sync_b[1] & ~sync_b[2];

  // Next counts fold in an edge seen this cycle so the final compare sees the last COUNT cycle.
  always_comb begin
    cnt_a_nx = cnt_a;
    cnt_b_nx = cnt_b;
    if (state_q == S_COUNT) begin
      if (edge_a && (cnt_a != CNT_MAX)) cnt_a_nx = cnt_a + CNT_W'(1);
      if (edge_b && (cnt_b != CNT_MAX)) cnt_b_nx = cnt_b + CNT_W'(1);
    end
  end

  assign window_end = (state_q == S_COUNT) && (timer == WINDOW_LAST);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          accept  = 1'b1;
        end
      end
      S_SETTLE: if (timer == SETTLE_LAST) state_d = S_COUNT;
      S_COUNT:  if (timer == WINDOW_LAST) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      sel_a  <= '0;
      sel_b  <= '0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      timer  <= '0;
      resp   <= 1'b0;
    end else begin
      sync_a <= {sync_a[1:0], ro_a};
      sync_b <= {sync_b[1:0], ro_b};
      if (accept) begin
        sel_a <= challenge[7:4];
        sel_b <= challenge[3:0];
        cnt_a <= '0;
        cnt_b <= '0;
        timer <= '0;
      end else begin
        cnt_a <= cnt_a_nx;
        cnt_b <= cnt_b_nx;
        if (state_d != state_q)
          timer <= '0;
        else if ((state_q == S_SETTLE) || (state_q == S_COUNT))
          timer <= timer + TW'(1);
      end
      if (window_end) resp <= (cnt_a_nx > cnt_b_nx);
    end
  end

`ifdef ROPUF_TIE_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             tie <= 1'b0;
    else if (window_end) tie <= (cnt_a_nx == cnt_b_nx);
  end
`endif

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_ro_pair_compare.sv
// Directed bench for ro_pair_compare: timing, response polarity, start filtering, saturation and mid-run reset.
module tb_ro_pair_compare;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] challenge;
  logic       ro_a, ro_b;
  logic [3:0] sel_a, sel_b, sel_a_s, sel_b_s;
  logic       busy, done, resp, busy_s, done_s, resp_s;
`ifdef ROPUF_TIE_FLAG_EN
  logic       tie, tie_s;
`endif

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;
  int unsigned pa = 8, pb = 12, k = 0;
  int unsigned ndone;

  always #5 clk = ~clk;

  ro_pair_compare #(.WINDOW(96), .SETTLE(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a), .sel_b(sel_b),
    .busy(busy), .done(done), .resp(resp)
`ifdef ROPUF_TIE_FLAG_EN
    , .tie(tie)
`endif
  );

  ro_pair_compare #(.WINDOW(96), .SETTLE(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a_s), .sel_b(sel_b_s),
    .busy(busy_s), .done(done_s), .resp(resp_s)
`ifdef ROPUF_TIE_FLAG_EN
    , .tie(tie_s)
`endif
  );

  // Oscillator stand-ins: periods in clk cycles, shared phase so equal periods are in phase.
  initial begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      k++;
      ro_a = ((k % pa) < (pa / 2));
      ro_b = ((k % pb) < (pb / 2));
    end
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue start at cycle 0, then check the cycle-100/101/102 boundaries of one comparison.
  task automatic run_cmp(input string tag, input logic [7:0] ch, input logic exp_resp);
    start = 1'b1;
    challenge = ch;
    step(1);
    start = 1'b0;
    check({tag, "_busy1"}, {3'b0, busy}, 4'h1);
    step(99);
    check({tag, "_done100"}, {3'b0, done}, 4'h0);
    step(1);
    check({tag, "_done101"}, {3'b0, done}, 4'h1);
    check({tag, "_resp"}, {3'b0, resp}, {3'b0, exp_resp});
    step(1);
    check({tag, "_busy102"}, {3'b0, busy}, 4'h0);
    check({tag, "_done102"}, {3'b0, done}, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    challenge = 8'h00;
    step(3);
    check("rst_sel_a", sel_a, 4'h0);
    check("rst_sel_b", sel_b, 4'h0);
    check("rst_busy", {3'b0, busy}, 4'h0);
    check("rst_done", {3'b0, done}, 4'h0);
    check("rst_resp", {3'b0, resp}, 4'h0);
`ifdef ROPUF_TIE_FLAG_EN
    check("rst_tie", {3'b0, tie}, 4'h0);
`endif
    rst = 1'b0;
    step(2);

    // A period 8, B period 12: A faster; second start while busy must be ignored.
    pa = 8; pb = 12;
    start = 1'b1;
    challenge = 8'hA5;
    step(1);
    start = 1'b0;
    check("a5_sel_a", sel_a, 4'hA);
    check("a5_sel_b", sel_b, 4'h5);
    check("a5_busy1", {3'b0, busy}, 4'h1);
    check("a5_done1", {3'b0, done}, 4'h0);
    step(19);
    start = 1'b1;
    challenge = 8'h3C;
    step(1);
    start = 1'b0;
    check("busy_start_sel_a", sel_a, 4'hA);
    check("busy_start_sel_b", sel_b, 4'h5);
    step(79);
    check("a5_done100", {3'b0, done}, 4'h0);
    step(1);
    check("a5_done101", {3'b0, done}, 4'h1);
    check("a5_resp", {3'b0, resp}, 4'h1);
    check("a5_busy101", {3'b0, busy}, 4'h1);
    step(1);
    check("a5_busy102", {3'b0, busy}, 4'h0);
    check("a5_resp_held", {3'b0, resp}, 4'h1);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      step(1);
    end
    check("single_done", ndone[3:0], 4'h0);
    check("sel_a_held", sel_a, 4'hA);

    // Swapped periods: B faster.
    pa = 12; pb = 8;
    run_cmp("swap", 8'h12, 1'b0);
    check("swap_sel_a", sel_a, 4'h1);
    check("swap_sel_b", sel_b, 4'h2);

    // Equal in-phase oscillators: equal counts give resp=0.
    pa = 8; pb = 8;
    run_cmp("equal", 8'h77, 1'b0);
`ifdef ROPUF_TIE_FLAG_EN
    check("equal_tie", {3'b0, tie}, 4'h1);
`endif

    // A period 4 (~24 edges), B period 8 (12 edges): 4-bit counter must saturate at 15, not wrap to ~8.
    pa = 4; pb = 8;
    run_cmp("sat", 8'hF0, 1'b1);
    check("sat_resp_cnt4", {3'b0, resp_s}, 4'h1);
`ifdef ROPUF_TIE_FLAG_EN
    check("sat_tie", {3'b0, tie}, 4'h0);
`endif

    // Reset mid-COUNT at cycle 50, then a full comparison afterwards.
    pa = 8; pb = 12;
    start = 1'b1;
    challenge = 8'hC3;
    step(1);
    start = 1'b0;
    step(49);
    rst = 1'b1;
    step(1);
    check("mrst_busy", {3'b0, busy}, 4'h0);
    check("mrst_done", {3'b0, done}, 4'h0);
    check("mrst_resp", {3'b0, resp}, 4'h0);
    check("mrst_sel_a", sel_a, 4'h0);
    check("mrst_sel_b", sel_b, 4'h0);
    rst = 1'b0;
    step(2);
    run_cmp("post_rst", 8'h9E, 1'b1);
    check("post_rst_sel_a", sel_a, 4'h9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ro_pair_compare.md
# ro_pair_compare

Ring-oscillator pair comparator for the RO PUF. Drives the select inputs of the two 16:1 RO multiplexers from an 8-bit challenge and counts rising edges of the two selected oscillator outputs over a fixed window. It then emits one response bit, A faster than B, to the key-generation logic. Sits directly downstream of the RO multiplexers and upstream of the response/key register.

## Interface

Parameters:
- WINDOW, 1024: count window length in clk cycles (≥1).
- SETTLE, 4: cycles to wait after select change before counting (≥1).
- CNT_W, 16: edge-counter width in bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin one comparison; sampled only in IDLE.
- challenge  input  8  [7:4] selects oscillator A, [3:0] selects oscillator B; captured with start.
- ro_a  input  1  selected RO output from mux A (asynchronous to clk).
- ro_b  input  1  selected RO output from mux B (asynchronous to clk).
- sel_a  output  4  select to mux A.
- sel_b  output  4  select to mux B.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; resp is valid in this cycle.
- resp  output  1  response bit, held until the next done.
- tie  output  1  present only with ROPUF_TIE_FLAG_EN (see Configuration).

## Operation

- ro_a and ro_b each pass through a 2-flop synchronizer and a rising-edge detector (third flop).
  - The detector runs continuously in all states.
  - An edge increments its counter only when detected while in COUNT.
- Counters cnt_a and cnt_b are CNT_W bits, unsigned. They saturate at 2^CNT_W−1 and never wrap.
- The state machine has four states: IDLE, SETTLE, COUNT, DONE.
  - IDLE: start=1 → SETTLE. Register sel_a=challenge[7:4] and sel_b=challenge[3:0], clear both counters and the settle/window counter. start=0 → stay in IDLE.
  - SETTLE: stay exactly SETTLE cycles, then → COUNT.
  - COUNT: stay exactly WINDOW cycles, then → DONE. On that transition, register resp = (cnt_a_final > cnt_b_final), strict compare, where each final count includes an edge detected in the last COUNT cycle.
  - DONE: done=1 for one cycle, then → IDLE.
- start is ignored outside IDLE, including in the DONE cycle.
- sel_a/sel_b are held from capture until the next accepted start.
- Equal counts give resp=0.
- Valid counting requires each RO frequency < clk/2. Faster signals alias; this is not detected.
- rst asserted in any state, mid-operation included, immediately forces:
  - state = IDLE;
  - counters, synchronizer and edge flops to 0;
  - all outputs to their reset values.

## Timing

- Reset values: sel_a=0, sel_b=0, busy=0, done=0, resp=0, tie=0.
- start high at cycle 0 (in IDLE):
  - cycle 1: sel updated, busy=1, state SETTLE;
  - cycles 1..SETTLE: SETTLE;
  - cycles SETTLE+1..SETTLE+WINDOW: COUNT;
  - cycle SETTLE+WINDOW+1: DONE, done=1, resp valid;
  - cycle SETTLE+WINDOW+2: IDLE, busy=0.
- The earliest next accepted start is at cycle SETTLE+WINDOW+2.
- Edge-to-count latency is 3 clk cycles (sync + detect). Edges arriving in the last 3 COUNT cycles may miss the window; this is accepted.

## Configuration

- ROPUF_TIE_FLAG_EN defined:
  - the tie output exists and is registered together with resp;
  - tie=1 in the DONE cycle, held until the next done, when cnt_a == cnt_b; otherwise tie=0;
  - tie resets to 0.
- ROPUF_TIE_FLAG_EN undefined: no tie port and no tie logic. resp behaviour is identical in both builds.

## Test plan

- Reset mid-COUNT (WINDOW=96, SETTLE=4) at cycle 50 → next cycle all outputs 0 and busy=0. A start after reset release runs a full comparison with done at start+101.
- ro_a period 8 clk, ro_b period 12 clk, WINDOW=96, SETTLE=4 → done at cycle 101, resp=1 (cnt_a≈12 > cnt_b≈8), busy low at cycle 102.
- Same as above with ro_a/ro_b swapped → resp=0.
- ro_a and ro_b both period 8, in phase → resp=0. With ROPUF_TIE_FLAG_EN, tie=1.
- challenge=0xA5 with start → sel_a=0xA, sel_b=0x5 at cycle 1. A second start with challenge=0x3C at cycle 20 (busy) → ignored, sel unchanged, one done only.
- CNT_W=4, ro_a period 4, ro_b period 8, WINDOW=96 → cnt_a saturates at 15 with no wrap, cnt_b=12, resp=1.
